// File: rtl/iso7816_3_card_responder_if.sv
// Host-side byte handshake of the ISO 7816-3 card responder.
// master = host/bench side, slave = responder core.
interface iso7816_3_card_responder_if;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic       txError;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxParityError;

  modport master (
    output txData, txValid,
    input  txReady, txError, rxData, rxValid, rxParityError
  );

  modport slave (
    input  txData, txValid,
    output txReady, txError, rxData, rxValid, rxParityError
  );
endinterface

// File: rtl/iso7816_3_card_responder.sv
// Card-side T=0 character link: sends TS after reset release, then
// half-duplex byte tx/rx with parity, error signalling and retransmission.
// All protocol timing is counted in ticks of the synchronized isoClk.
module iso7816_3_card_responder #(
  parameter int CLK_PER_ETU  = 372,
  parameter int ATR_DELAY    = 400,
  parameter bit INDIRECT     = 1'b0,
  parameter int MAX_TX_TRIES = 4
) (
  input  logic clk,
  input  logic nReset,
  input  logic i_isoVdd,
  input  logic i_isoReset,
  input  logic i_isoClk,
  input  logic i_sioIn,
  output logic o_sioDriveLow,
  output logic o_cardActive,
  iso7816_3_card_responder_if.slave host
);

  localparam logic [15:0] L_ETU_M1 = 16'(CLK_PER_ETU - 1);
  localparam logic [15:0] L_HALF   = 16'(CLK_PER_ETU / 2);
  localparam logic [15:0] L_ATR_M1 = 16'(ATR_DELAY - 1);
  localparam logic [7:0]  L_MAXT   = 8'(MAX_TX_TRIES);
  localparam logic [7:0]  L_TS     = INDIRECT ? 8'h3F : 8'h3B;

  typedef enum logic [2:0] {S_OFF, S_RST, S_ATRW, S_IDLE, S_TX, S_RX} state_t;

  function automatic logic [7:0] f_rev(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // Line levels for bits 0..9 (1 = released/high); start bit always low.
  function automatic logic [9:0] f_enc(input logic [7:0] d);
    if (INDIRECT) return {~(^d), ~f_rev(d), 1'b0};
    else          return {^d, d, 1'b0};
  endfunction

  state_t      r_state, w_state_n;
  logic [1:0]  r_vdd_s, r_rst_s, r_io_s;
  logic [2:0]  r_clk_s;
  logic [15:0] r_atr, r_etu, w_etu_n;
  logic [3:0]  r_bit, w_bit_n;
  logic [9:0]  r_line;
  logic [8:0]  r_rxsh;
  logic [7:0]  r_tries, r_rxdata;
  logic        r_nak, r_perr, r_txerr, r_rxv, r_perr_p, r_drive;
  logic        w_vdd, w_rst, w_io, w_tick, w_edge, w_half;
  logic        w_load_ts, w_accept, w_restart, w_cnt_clr, w_cnt_run;
  logic        w_tx_smp, w_rx_smp, w_rx_end, w_err_set, w_err_clr;
  logic        w_txrdy, w_drive, w_rx_good;
  logic [7:0]  w_rx_byte;

  // Two-flop synchronizers; isoClk gets a third flop for rising-edge detect.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_vdd_s <= '0;
      r_rst_s <= '0;
      r_io_s  <= 2'b11;
      r_clk_s <= '0;
    end else begin
      r_vdd_s <= {r_vdd_s[0], i_isoVdd};
      r_rst_s <= {r_rst_s[0], i_isoReset};
      r_io_s  <= {r_io_s[0], i_sioIn};
      r_clk_s <= {r_clk_s[1:0], i_isoClk};
    end
  end

  assign w_vdd   = r_vdd_s[1];
  assign w_rst   = r_rst_s[1];
  assign w_io    = r_io_s[1];
  assign w_tick  = r_clk_s[1] & ~r_clk_s[2];
  assign w_etu_n = (r_etu == L_ETU_M1) ? 16'd0 : r_etu + 16'd1;
  assign w_bit_n = (r_etu == L_ETU_M1) ? r_bit + 4'd1 : r_bit;
  // w_edge: tick that starts ETU w_bit_n; w_half: tick at mid-ETU of w_bit_n.
  assign w_edge  = w_tick && (r_etu == L_ETU_M1);
  assign w_half  = w_tick && (w_etu_n == L_HALF);

  assign w_rx_good = INDIRECT ? (^r_rxsh) : ~(^r_rxsh);
  assign w_rx_byte = INDIRECT ? ~f_rev(r_rxsh[7:0]) : r_rxsh[7:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!nReset) r_state <= S_OFF;
    else         r_state <= w_state_n;
  end

  // Next state and per-cycle control strobes; abort overrides everything.
  always_comb begin
    w_state_n = r_state;
    w_load_ts = 1'b0;
    w_accept  = 1'b0;
    w_restart = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_run = 1'b0;
    w_tx_smp  = 1'b0;
    w_rx_smp  = 1'b0;
    w_rx_end  = 1'b0;
    w_err_set = 1'b0;
    w_err_clr = 1'b0;
    w_txrdy   = 1'b0;
    w_drive   = 1'b0;
    case (r_state)
      S_OFF: begin
        w_err_clr = 1'b1;
        if (w_vdd) w_state_n = S_RST;
      end
      S_RST: begin
        w_err_clr = 1'b1;
        if (!w_vdd)     w_state_n = S_OFF;
        else if (w_rst) w_state_n = S_ATRW;
      end
      S_ATRW: begin
        if (w_tick && r_atr == L_ATR_M1) begin
          w_load_ts = 1'b1;
          w_state_n = S_TX;
        end
      end
      S_IDLE: begin
        w_txrdy = 1'b1;
        if (host.txValid) begin
          w_accept  = 1'b1;
          w_state_n = S_TX;
        end else if (w_tick && !w_io) begin
          w_cnt_clr = 1'b1;
          w_state_n = S_RX;
        end
      end
      S_TX: begin
        w_cnt_run = 1'b1;
        w_drive   = (r_bit < 4'd10) && !r_line[r_bit];
        if (w_half && w_bit_n == 4'd10) w_tx_smp = 1'b1;
        if (w_edge && w_bit_n == 4'd12 && !r_nak) w_state_n = S_IDLE;
        // Only reachable after a NAK, since a clean character ends at 12 ETU.
        if (w_edge && w_bit_n == 4'd13) begin
          if (r_tries < L_MAXT) w_restart = 1'b1;
          else begin
            w_err_set = 1'b1;
            w_state_n = S_IDLE;
          end
        end
      end
      S_RX: begin
        w_cnt_run = 1'b1;
        w_drive   = r_perr && ((r_bit == 4'd10 && r_etu >= L_HALF) ||
                               (r_bit == 4'd11 && r_etu <  L_HALF));
        if (w_half && w_bit_n == 4'd0 && w_io) w_state_n = S_IDLE;
        if (w_half && w_bit_n >= 4'd1 && w_bit_n <= 4'd9) w_rx_smp = 1'b1;
        if (w_edge && w_bit_n == 4'd10) w_rx_end = 1'b1;
        if (w_edge && w_bit_n == 4'd11 && !r_perr) w_state_n = S_IDLE;
        if (w_edge && w_bit_n == 4'd12) w_state_n = S_IDLE;
      end
      default: w_state_n = S_OFF;
    endcase
    if (r_state != S_OFF && r_state != S_RST && !(w_vdd && w_rst)) begin
      w_state_n = w_vdd ? S_RST : S_OFF;
      w_load_ts = 1'b0;
      w_accept  = 1'b0;
      w_restart = 1'b0;
      w_cnt_clr = 1'b0;
      w_tx_smp  = 1'b0;
      w_rx_smp  = 1'b0;
      w_rx_end  = 1'b0;
      w_err_set = 1'b0;
      w_err_clr = 1'b1;
      w_txrdy   = 1'b0;
      w_drive   = 1'b0;
    end
  end

  // Bit timing, character shift data, try count and host-facing flags.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_atr    <= '0;
      r_etu    <= '0;
      r_bit    <= '0;
      r_line   <= '1;
      r_rxsh   <= '0;
      r_tries  <= '0;
      r_rxdata <= '0;
      r_nak    <= 1'b0;
      r_perr   <= 1'b0;
      r_txerr  <= 1'b0;
      r_rxv    <= 1'b0;
      r_perr_p <= 1'b0;
      r_drive  <= 1'b0;
    end else begin
      r_rxv    <= 1'b0;
      r_perr_p <= 1'b0;
      r_drive  <= w_drive;

      if (r_state != S_ATRW) r_atr <= '0;
      else if (w_tick)       r_atr <= r_atr + 16'd1;

      if (w_cnt_clr || w_load_ts || w_accept || w_restart) begin
        r_etu  <= '0;
        r_bit  <= '0;
        r_nak  <= 1'b0;
        r_perr <= 1'b0;
      end else if (w_cnt_run && w_tick) begin
        r_etu <= w_etu_n;
        r_bit <= w_bit_n;
      end

      if (w_load_ts) begin
        r_line  <= f_enc(L_TS);
        r_tries <= '0;
      end
      if (w_accept) begin
        r_line  <= f_enc(host.txData);
        r_tries <= '0;
      end
      if (w_tx_smp && !w_io) begin
        r_nak   <= 1'b1;
        r_tries <= r_tries + 8'd1;
      end

      if (w_err_clr)      r_txerr <= 1'b0;
      else if (w_err_set) r_txerr <= 1'b1;

      if (w_rx_smp) r_rxsh <= {w_io, r_rxsh[8:1]};
      if (w_rx_end) begin
        if (w_rx_good) begin
          r_rxdata <= w_rx_byte;
          r_rxv    <= 1'b1;
        end else begin
          r_perr   <= 1'b1;
          r_perr_p <= 1'b1;
        end
      end
    end
  end

  assign o_sioDriveLow      = r_drive;
  assign o_cardActive       = w_vdd & w_rst;
  assign host.txReady       = w_txrdy;
  assign host.txError       = r_txerr;
  assign host.rxData        = r_rxdata;
  assign host.rxValid       = r_rxv;
  assign host.rxParityError = r_perr_p;

endmodule

// File: tb/tb_iso7816_3_card_responder.sv
// Directed bench: two responders (direct and inverse convention), clk/4 isoClk,
// ETU = 4 ticks = 16 clk, reader modelled as an open-drain puller on the line.
module tb_iso7816_3_card_responder;

  logic clk = 1'b0, nReset = 1'b0, isoClk = 1'b0;
  logic vdd0 = 1'b0, rst0 = 1'b0, vdd1 = 1'b0, rst1 = 1'b0, rdr_low = 1'b0;
  logic drv0, drv1, act0, act1, line0, line1;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  assign line0 = ~(drv0 | rdr_low);
  assign line1 = ~drv1;

  iso7816_3_card_responder_if h0 ();
  iso7816_3_card_responder_if h1 ();

  iso7816_3_card_responder #(.CLK_PER_ETU(4), .ATR_DELAY(20), .INDIRECT(1'b0), .MAX_TX_TRIES(4)) u_dir (
    .clk(clk), .nReset(nReset), .i_isoVdd(vdd0), .i_isoReset(rst0), .i_isoClk(isoClk),
    .i_sioIn(line0), .o_sioDriveLow(drv0), .o_cardActive(act0), .host(h0));

  iso7816_3_card_responder #(.CLK_PER_ETU(4), .ATR_DELAY(20), .INDIRECT(1'b1), .MAX_TX_TRIES(4)) u_inv (
    .clk(clk), .nReset(nReset), .i_isoVdd(vdd1), .i_isoReset(rst1), .i_isoClk(isoClk),
    .i_sioIn(line1), .o_sioDriveLow(drv1), .o_cardActive(act1), .host(h1));

  always #5  clk = ~clk;
  always #20 isoClk = ~isoClk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_drive0(input int limit, output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (drv0) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  // Called at the negedge where the start bit was first seen; samples bit centres.
  task automatic grab_char0(output logic [9:0] lv);
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 8 : 16) @(negedge clk);
      lv[k] = ~drv0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (drv0 !== 1'b0) begin errors++; $display("FAIL reset_drive: got %b want 0", drv0); end
    checks++; if (h0.txReady !== 1'b0 || h0.txError !== 1'b0) begin errors++;
      $display("FAIL reset_tx: txReady=%b txError=%b want 0/0", h0.txReady, h0.txError); end
    checks++; if (h0.rxData !== 8'h00 || h0.rxValid !== 1'b0 || h0.rxParityError !== 1'b0) begin errors++;
      $display("FAIL reset_rx: rxData=%h rxValid=%b rxPE=%b want 00/0/0", h0.rxData, h0.rxValid, h0.rxParityError); end
    checks++; if (act0 !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", act0); end
    nReset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (h0.txReady !== 1'b0 || act0 !== 1'b0) begin errors++;
      $display("FAIL off_state: txReady=%b active=%b want 0/0", h0.txReady, act0); end
  endtask

  task automatic test_ts_direct(input string tag);
    int t0, t; bit ok; logic [9:0] lv;
    @(negedge clk); rst0 = 1'b1; t0 = cyc;
    wait_drive0(200, t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_start: no TS start bit within 200 clk", tag); return; end
    checks++; if (t - t0 < 76 || t - t0 > 92) begin errors++;
      $display("FAIL %s_delay: start %0d clk after reset release, want 76..92", tag, t - t0); end
    checks++; if (act0 !== 1'b1) begin errors++; $display("FAIL %s_active: got %b want 1", tag, act0); end
    grab_char0(lv);
    checks++; if (lv !== 10'b1001110110) begin errors++;
      $display("FAIL %s_levels: got %b want %b", tag, lv, 10'b1001110110); end
    repeat (32) @(negedge clk);
    checks++; if (h0.txReady !== 1'b0) begin errors++; $display("FAIL %s_ready_early: got %b want 0 at 11.5 ETU", tag, h0.txReady); end
    repeat (16) @(negedge clk);
    checks++; if (h0.txReady !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1 at 12.5 ETU", tag, h0.txReady); end
  endtask

  task automatic test_ts_inverse;
    int t0, dt; bit ok; logic [9:0] lv;
    @(negedge clk); vdd1 = 1'b1;
    repeat (4) @(negedge clk); rst1 = 1'b1; t0 = cyc; ok = 1'b0; dt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (drv1) begin ok = 1'b1; dt = cyc - t0; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL inv_start: no TS start bit within 200 clk"); return; end
    checks++; if (dt < 76 || dt > 92) begin errors++; $display("FAIL inv_delay: got %0d clk want 76..92", dt); end
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 8 : 16) @(negedge clk);
      lv[k] = ~drv1;
    end
    checks++; if (lv !== 10'b1000000110) begin errors++;
      $display("FAIL inv_levels: got %b want %b", lv, 10'b1000000110); end
    repeat (48) @(negedge clk);
    checks++; if (h1.txReady !== 1'b1 || act1 !== 1'b1) begin errors++;
      $display("FAIL inv_idle: txReady=%b active=%b want 1/1", h1.txReady, act1); end
  endtask

  task automatic test_rx;
    logic [7:0] dat [3] = '{8'hA5, 8'hA5, 8'h3C};
    logic       par [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] exp_rx;
    exp_rx = 8'h00;
    for (int c = 0; c < 3; c++) begin
      logic [9:0] lv;
      int nv, np, fd, ld, vat;
      bit good;
      lv = {par[c], dat[c], 1'b0};
      good = (^dat[c]) == par[c];
      nv = 0; np = 0; fd = -1; ld = -1; vat = -1;
      fork
        begin
          for (int k = 0; k < 10; k++) begin rdr_low = ~lv[k]; repeat (16) @(negedge clk); end
          rdr_low = 1'b0;
        end
        begin
          for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (h0.rxValid) begin nv++; vat = i; end
            if (h0.rxParityError) np++;
            if (drv0) begin if (fd < 0) fd = i; ld = i; end
          end
        end
      join
      if (good) exp_rx = dat[c];
      checks++; if (h0.rxData !== exp_rx) begin errors++; $display("FAIL rx%0d_data: got %h want %h", c, h0.rxData, exp_rx); end
      checks++; if (nv != (good ? 1 : 0) || np != (good ? 0 : 1)) begin errors++;
        $display("FAIL rx%0d_pulses: rxValid cycles=%0d rxPE cycles=%0d want %0d/%0d", c, nv, np, good ? 1 : 0, good ? 0 : 1); end
      if (good) begin
        checks++; if (vat < 152 || vat > 172) begin errors++; $display("FAIL rx%0d_valid_time: at %0d clk want 152..172", c, vat); end
        checks++; if (fd != -1) begin errors++; $display("FAIL rx%0d_no_drive: line driven at %0d clk want never", c, fd); end
      end else begin
        checks++; if (fd < 162 || fd > 182) begin errors++; $display("FAIL rx%0d_err_start: drive at %0d clk want 162..182", c, fd); end
        checks++; if (ld - fd + 1 < 14 || ld - fd + 1 > 18) begin errors++;
          $display("FAIL rx%0d_err_len: drive %0d clk want 14..18", c, ld - fd + 1); end
      end
    end
  endtask

  task automatic test_tx_ok;
    int t, nd; bit ok; logic [9:0] lv;
    @(negedge clk);
    checks++; if (h0.txReady !== 1'b1) begin errors++; $display("FAIL txok_ready: got %b want 1", h0.txReady); end
    h0.txData = 8'hC3; h0.txValid = 1'b1;
    @(negedge clk); h0.txValid = 1'b0;
    checks++; if (h0.txReady !== 1'b0) begin errors++; $display("FAIL txok_ready_drop: got %b want 0", h0.txReady); end
    wait_drive0(10, t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL txok_start: no start bit seen"); return; end
    grab_char0(lv);
    checks++; if (lv !== {1'b0, 8'hC3, 1'b0}) begin errors++; $display("FAIL txok_levels: got %b want %b", lv, {1'b0, 8'hC3, 1'b0}); end
    repeat (16) @(negedge clk);
    nd = 0;
    for (int i = 0; i < 300; i++) begin @(negedge clk); if (drv0) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL txok_single: %0d extra drive cycles want 0", nd); end
    checks++; if (h0.txReady !== 1'b1 || h0.txError !== 1'b0) begin errors++;
      $display("FAIL txok_done: txReady=%b txError=%b want 1/0", h0.txReady, h0.txError); end
  endtask

  task automatic test_tx_retry;
    int t, tp, nd; bit ok; logic [9:0] lv;
    @(negedge clk); h0.txData = 8'h90; h0.txValid = 1'b1;
    @(negedge clk); h0.txValid = 1'b0;
    tp = 0;
    for (int a = 0; a < 4; a++) begin
      wait_drive0(a == 0 ? 10 : 40, t, ok);
      checks++;
      if (!ok) begin errors++; rdr_low = 1'b0; $display("FAIL retry_start%0d: no start bit seen", a); return; end
      if (a > 0) begin
        checks++; if (t - tp < 202 || t - tp > 212) begin errors++;
          $display("FAIL retry_gap%0d: got %0d clk want 202..212", a, t - tp); end
      end
      tp = t;
      if (a == 0) begin
        grab_char0(lv);
        checks++; if (lv !== {1'b0, 8'h90, 1'b0}) begin errors++; $display("FAIL retry_levels: got %b want %b", lv, {1'b0, 8'h90, 1'b0}); end
      end else repeat (152) @(negedge clk);
      repeat (10) @(negedge clk); rdr_low = 1'b1;
      repeat (18) @(negedge clk); rdr_low = 1'b0;
      if (a == 2) begin
        checks++; if (h0.txError !== 1'b0) begin errors++; $display("FAIL retry_err_early: got %b want 0", h0.txError); end
      end
    end
    repeat (36) @(negedge clk);
    checks++; if (h0.txError !== 1'b1 || h0.txReady !== 1'b1) begin errors++;
      $display("FAIL retry_giveup: txError=%b txReady=%b want 1/1", h0.txError, h0.txReady); end
    nd = 0;
    for (int i = 0; i < 480; i++) begin @(negedge clk); if (drv0) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL retry_fifth: %0d drive cycles after give-up want 0", nd); end
  endtask

  task automatic test_abort;
    int t; bit ok;
    @(negedge clk); h0.txData = 8'h00; h0.txValid = 1'b1;
    @(negedge clk); h0.txValid = 1'b0;
    wait_drive0(10, t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_start: no start bit seen"); return; end
    repeat (80) @(negedge clk);
    checks++; if (drv0 !== 1'b1) begin errors++; $display("FAIL abort_pre: drive=%b want 1 at 5 ETU", drv0); end
    rst0 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (drv0 !== 1'b0) begin errors++; $display("FAIL abort_release: drive=%b want 0 within 3 clk", drv0); end
    checks++; if (act0 !== 1'b0 || h0.txReady !== 1'b0 || h0.txError !== 1'b0) begin errors++;
      $display("FAIL abort_state: active=%b txReady=%b txError=%b want 0/0/0", act0, h0.txReady, h0.txError); end
    repeat (20) @(negedge clk);
    test_ts_direct("ts_again");
  endtask

  initial begin
    h0.txData = 8'h00; h0.txValid = 1'b0;
    h1.txData = 8'h00; h1.txValid = 1'b0;
    test_reset();
    @(negedge clk); vdd0 = 1'b1;
    repeat (4) @(negedge clk);
    test_ts_direct("ts");
    test_ts_inverse();
    test_rx();
    test_tx_ok();
    test_tx_retry();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
